// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the operator-entry front end and the core
// decoder of the switch-driven 4-bit CPU.
//   * opcode encodings (OP_ADD .. OP_XOR, OP_ST, OP_LD)
//   * op_operand_count(): operand count of an opcode (0 = invalid opcode)
//   * entry_state_t: entry FSM encoding, chosen so it can drive the phase LEDs
package cpu_pkg;

  // Two-operand opcodes
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1011;

  // One-operand opcodes (operand A only)
  localparam logic [3:0] OP_ST   = 4'b1111;
  localparam logic [3:0] OP_LD   = 4'b1110;

  // Entry phase; the encoding is what the operator sees on the LEDs
  typedef enum logic [1:0] {
    ENTRY_IDLE  = 2'b00,
    ENTRY_GET_A = 2'b01,
    ENTRY_GET_B = 2'b10,
    ENTRY_ISSUE = 2'b11
  } entry_state_t;

  // Number of operands an opcode takes; 0 flags an unknown opcode
  function automatic logic [1:0] op_operand_count(input logic [3:0] op);
    logic [1:0] count;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_CMP,
      OP_NAND, OP_NOR, OP_XOR:          count = 2'd2;
      OP_ST, OP_LD:                     count = 2'd1;
      default:                          count = 2'd0;
    endcase
    return count;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce -- push-button conditioner: 2-flop synchronizer, stability
// counter, debounced level and a registered one-cycle press pulse on the
// level's 0->1 edge. A clean press yields press DEBOUNCE_CYCLES+3 cycles after
// the raw button rises; releases are filtered the same way but give no pulse.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   btn    in  raw, asynchronous button
//   press  out one-cycle pulse per accepted press
// Parameters: DEBOUNCE_CYCLES (stable cycles required), CNT_W (counter width,
// 2^CNT_W must exceed DEBOUNCE_CYCLES).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;
  logic             level;
  logic             level_d;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

  // Stability counter; the level only follows after a full run of mismatch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= CNT_ZERO;
      level <= 1'b0;
    end else if (sync_2 != level) begin
      if (cnt == CNT_LAST) begin
        level <= sync_2;
        cnt   <= CNT_ZERO;
      end else begin
        cnt   <= cnt + CNT_ONE;
      end
    end else begin
      // Any return to agreement restarts the count, which kills glitches
      cnt <= CNT_ZERO;
    end
  end

  // Registered rising-edge detector on the debounced level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/instr_entry.sv
// instr_entry -- operator-input front end of the 4-bit CPU. Collects one
// instruction as a sequence of debounced Done presses (opcode on sw[3:0], then
// 0/1/2 operands on sw[7:4]) and offers it to the core over valid/ready.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   done_btn     in   raw Done push-button
//   sw[7:0]      in   switches: [3:0] opcode field, [7:4] operand field
//   instr_ready  in   core takes the instruction this cycle (used in ISSUE only)
//   instr_valid  out  instruction valid and held stable
//   instr_op     out  opcode
//   instr_a      out  first operand (0 if unused)
//   instr_b      out  second operand (0 if unused)
//   bad_op       out  one-cycle pulse after an unknown opcode press
//   led[1:0]     out  entry phase: 00 idle, 01 A, 10 B, 11 issuing
module instr_entry
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       done_btn,
  input  logic [7:0] sw,
  input  logic       instr_ready,
  output logic       instr_valid,
  output logic [3:0] instr_op,
  output logic [3:0] instr_a,
  output logic [3:0] instr_b,
  output logic       bad_op,
  output logic [1:0] led
);

  entry_state_t state;
  entry_state_t state_next;
  logic         press;
  logic         single;
  logic         single_next;
  logic [3:0]   op_next;
  logic [3:0]   a_next;
  logic [3:0]   b_next;
  logic         valid_next;
  logic         bad_next;
  logic [1:0]   op_count;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .btn   (done_btn),
    .press (press)
  );

  assign op_count = op_operand_count(sw[3:0]);

  // LEDs show the registered entry phase directly
  assign led = state;

  // State and instruction registers; every output leaves a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ENTRY_IDLE;
      single      <= 1'b0;
      instr_op    <= 4'h0;
      instr_a     <= 4'h0;
      instr_b     <= 4'h0;
      instr_valid <= 1'b0;
      bad_op      <= 1'b0;
    end else begin
      state       <= state_next;
      single      <= single_next;
      instr_op    <= op_next;
      instr_a     <= a_next;
      instr_b     <= b_next;
      instr_valid <= valid_next;
      bad_op      <= bad_next;
    end
  end

  // Entry sequencing: next state and next register values
  always_comb begin
    state_next  = state;
    single_next = single;
    op_next     = instr_op;
    a_next      = instr_a;
    b_next      = instr_b;
    bad_next    = 1'b0;
    valid_next  = 1'b0;

    case (state)
      ENTRY_IDLE: begin
        if (press) begin
          if (op_count == 2'd0) begin
            // Unknown opcode: flag it and keep the previous instruction
            bad_next = 1'b1;
          end else begin
            op_next     = sw[3:0];
            a_next      = 4'h0;
            b_next      = 4'h0;
            single_next = (op_count == 2'd1);
            state_next  = ENTRY_GET_A;
          end
        end else begin
          state_next = ENTRY_IDLE;
        end
      end

      ENTRY_GET_A: begin
        if (press) begin
          a_next = sw[7:4];
          if (single) begin
            b_next     = 4'h0;
            state_next = ENTRY_ISSUE;
          end else begin
            state_next = ENTRY_GET_B;
          end
        end else begin
          state_next = ENTRY_GET_A;
        end
      end

      ENTRY_GET_B: begin
        if (press) begin
          b_next     = sw[7:4];
          state_next = ENTRY_ISSUE;
        end else begin
          state_next = ENTRY_GET_B;
        end
      end

      ENTRY_ISSUE: begin
        // Presses here are dropped; only the core's ready moves us on
        if (instr_ready) begin
          state_next = ENTRY_IDLE;
        end else begin
          state_next = ENTRY_ISSUE;
        end
      end

      default: begin
        state_next = ENTRY_IDLE;
      end
    endcase

    // Valid is a registered copy of "next state is ISSUE"
    valid_next = (state_next == ENTRY_ISSUE);
  end

endmodule
